md_unit_scheduler: RTL and testbench
====================================

// Module: md_unit_scheduler
// PURPOSE
//  Multiply/divide scheduler for the P7 pipeline: accepts decoded mult/multu/div/divu/
//  mthi/mtlo from the E stage, models fixed MIPS latency with a busy countdown,
//  owns the HI/LO registers, and generates the D-stage stall for dependent md instructions.
//  Sits beside the E-stage ALU; takes the one-hot decode lines and cancel from the exception unit.
// PARAMETERS
//  MULT_LAT  5   busy cycles for mult/multu (>=1)
//  DIV_LAT   10  busy cycles for div/divu (>=1)
// PORTS
//  clk       in   1   rising-edge clock
//  rst_n     in   1   asynchronous active-low reset
//  mult      in   1   E-stage signed multiply
//  multu     in   1   E-stage unsigned multiply
//  div       in   1   E-stage signed divide
//  divu      in   1   E-stage unsigned divide
//  mthi      in   1   E-stage write HI from rs_val
//  mtlo      in   1   E-stage write LO from rs_val
//  cancel    in   1   exception/interrupt this cycle: E-stage md op must have no effect
//  rs_val    in   32  forwarded rs operand (dividend / multiplicand / mt source)
//  rt_val    in   32  forwarded rt operand (divisor / multiplier)
//  d_md_use  in   1   D-stage instr is any md op (mult..divu, mfhi, mflo, mthi, mtlo)
//  busy      out  1   operation in flight
//  stall     out  1   freeze F/D, bubble E
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  - Reset (rst_n=0, async): cnt=0, busy=0, hi=0, lo=0, pending result=0; stall=0 combinationally.
//  - At most one md input high per cycle (decoder guarantee); op = OR of the six.
//  - accept = (mult|multu|div|divu) & ~cancel & ~busy. Operand result computed at accept
//    and held in pend_hi/pend_lo; later rs_val/rt_val changes are ignored.
//  - States IDLE (cnt==0), RUN (cnt!=0). IDLE->RUN on accept: cnt<=MULT_LAT or DIV_LAT.
//    RUN: cnt decrements each edge; edge with cnt==1 writes hi<=pend_hi, lo<=pend_lo, ->IDLE.
//  - busy = (cnt!=0): op seen in cycle 0 -> busy high cycles 1..LAT, hi/lo new in cycle LAT+1.
//  - stall = d_md_use & (busy | accept) (combinational); covers back-to-back md ops.
//  - md op arriving while busy is ignored (stall prevents it); bench asserts it never occurs.
//  - mthi/mtlo: if ~cancel & ~busy, hi/lo <= rs_val at next edge; no busy.
//  - cancel=1: that cycle's E-stage op causes no state change; in-flight RUN continues
//    unaffected (already committed).
//  - mult: signed 32x32->64; multu unsigned; {hi,lo}=product.
//  - div: lo=quotient truncated toward zero, hi=remainder with dividend sign;
//    0x80000000/-1 -> lo=0x80000000, hi=0.
//  - divu: unsigned quotient/remainder.
//  - Divisor 0 (div/divu): still busy DIV_LAT cycles; hi/lo left unchanged at completion.
//  - Reset mid-RUN: pending result discarded, all outputs to reset values immediately.
// TESTING
//  - mult rs=-3(0xFFFFFFFD) rt=5 -> busy 5 cycles; then hi=0xFFFFFFFF lo=0xFFFFFFF1.
//  - multu 0xFFFFFFFF*2 -> hi=0x00000001 lo=0xFFFFFFFE after 5 busy cycles.
//  - divu 100/7 -> busy 10 cycles, lo=14, hi=2.
//  - div -7/2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//  - div 0x80000000/-1 -> lo=0x80000000 hi=0.
//  - div by 0 with hi=0x11, lo=0x22 -> busy 10 cycles, hi/lo unchanged.
//  - mult accepted, d_md_use=1 (mflo) -> stall high accept cycle + 5 busy cycles, low after.
//  - mult with cancel=1 -> busy stays 0, hi/lo unchanged, stall=d_md_use&0=0.
//  - mthi rs=0xDEADBEEF idle -> hi=0xDEADBEEF next cycle, busy 0.
//  - rst_n low at busy cycle 3 of div -> busy=0 hi=lo=0 at once; no late write after release.

Source files
------------

// File: rtl/md_unit_scheduler.sv
// Multiply/divide scheduler: fixed-latency busy countdown, HI/LO ownership,
// and D-stage stall generation for dependent md instructions.
module md_unit_scheduler #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mult,
  input  logic        multu,
  input  logic        div,
  input  logic        divu,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        cancel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          md_start, accept, mt_ok, commit;
  logic [31:0]   hi_q, lo_q, pend_hi, pend_lo;
  logic          pend_we;

  logic [63:0]   sprod, uprod;
  logic [31:0]   dvd, dvs, uq, ur;
  logic [31:0]   res_hi, res_lo;
  logic          res_we;

  assign md_start = mult | multu | div | divu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = (div | divu) ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy   = (state_q == RUN);
    accept = md_start & ~cancel & ~busy;
    mt_ok  = ~cancel & ~busy;
    commit = (state_q == RUN) && (cnt_q == CW'(1));
    stall  = d_md_use & (busy | accept);
  end

  // One unsigned divider serves both div and divu; signed div works on
  // magnitudes and fixes signs afterwards, which also yields 0x80000000/-1.
  always_comb begin
    sprod = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    uprod = {32'b0, rs_val} * {32'b0, rt_val};
    dvd   = rs_val;
    dvs   = rt_val;
    if (div) begin
      dvd = rs_val[31] ? -rs_val : rs_val;
      dvs = rt_val[31] ? -rt_val : rt_val;
    end
    if (dvs == '0) begin
      uq = '0;
      ur = '0;
    end else begin
      uq = dvd / dvs;
      ur = dvd % dvs;
    end
    res_we = 1'b1;
    res_hi = '0;
    res_lo = '0;
    if (mult) begin
      res_hi = sprod[63:32];
      res_lo = sprod[31:0];
    end else if (multu) begin
      res_hi = uprod[63:32];
      res_lo = uprod[31:0];
    end else if (div) begin
      res_we = (rt_val != '0);
      res_lo = (rs_val[31] ^ rt_val[31]) ? -uq : uq;
      res_hi = rs_val[31] ? -ur : ur;
    end else if (divu) begin
      res_we = (rt_val != '0);
      res_lo = uq;
      res_hi = ur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
    end else begin
      if (accept) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_we <= res_we;
      end
      if (commit && pend_we) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
      if (mthi && mt_ok) hi_q <= rs_val;
      if (mtlo && mt_ok) lo_q <= rs_val;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_md_unit_scheduler.sv
// Directed-vector bench for md_unit_scheduler with hand-computed HI/LO results.
module tb_md_unit_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mult = 1'b0, multu = 1'b0, div = 1'b0, divu = 1'b0;
  logic        mthi = 1'b0, mtlo = 1'b0, cancel = 1'b0, d_md_use = 1'b0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int unsigned vecs = 0;
  int unsigned errs = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  md_unit_scheduler #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .mult(mult), .multu(multu), .div(div), .divu(divu),
    .mthi(mthi), .mtlo(mtlo), .cancel(cancel),
    .rs_val(rs_val), .rt_val(rt_val), .d_md_use(d_md_use),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // op: 0 mult, 1 multu, 2 div, 3 divu
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic use_d, input logic [31:0] eh,
                        input logic [31:0] el, input string tag);
    rs_val = a; rt_val = b; d_md_use = use_d;
    mult = (op == 0); multu = (op == 1); div = (op == 2); divu = (op == 3);
    #1;
    chk({tag, "_stall_acc"}, {31'b0, stall}, {31'b0, use_d});
    tick();
    mult = 0; multu = 0; div = 0; divu = 0;
    rs_val = 32'hA5A5A5A5; rt_val = '0;
    for (int i = 1; i <= lat; i++) begin
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      if (use_d) chk({tag, "_stall_busy"}, {31'b0, stall}, 32'd1);
      if (i == lat) begin
        chk({tag, "_hi_hold"}, hi, m_hi);
        chk({tag, "_lo_hold"}, lo, m_lo);
      end
      tick();
    end
    chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
    chk({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    m_hi = eh; m_lo = el;
    d_md_use = 0;
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op(0, 32'hFFFFFFFD, 32'd5, 5, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg");
    run_op(1, 32'hFFFFFFFF, 32'd2, 5, 1'b0, 32'h00000001, 32'hFFFFFFFE, "multu");
    run_op(3, 32'd100, 32'd7, 10, 1'b0, 32'd2, 32'd14, "divu");
    run_op(2, 32'hFFFFFFF9, 32'd2, 10, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    run_op(2, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 32'h0, 32'h80000000, "div_ovf");

    mthi = 1; rs_val = 32'hDEADBEEF; tick(); mthi = 0; rs_val = '0;
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk("mthi_lo", lo, 32'h80000000);
    mthi = 1; rs_val = 32'h11; tick(); mthi = 0;
    mtlo = 1; rs_val = 32'h22; tick(); mtlo = 0;
    chk("mt_hi", hi, 32'h11);
    chk("mt_lo", lo, 32'h22);
    m_hi = 32'h11; m_lo = 32'h22;

    run_op(2, 32'd7, 32'd0, 10, 1'b0, 32'h11, 32'h22, "div_zero");
    run_op(0, 32'd7, 32'd6, 5, 1'b1, 32'h0, 32'h2A, "mult_stall");

    cancel = 1; mult = 1; rs_val = 32'd3; rt_val = 32'd3; d_md_use = 1;
    #1;
    chk("cancel_stall", {31'b0, stall}, 32'd0);
    tick();
    mult = 0; d_md_use = 0;
    chk("cancel_busy", {31'b0, busy}, 32'd0);
    chk("cancel_hi", hi, 32'h0);
    chk("cancel_lo", lo, 32'h2A);
    mtlo = 1; rs_val = 32'h77; tick(); mtlo = 0; cancel = 0;
    chk("cancel_mtlo", lo, 32'h2A);

    div = 1; rs_val = 32'd100; rt_val = 32'd3; tick(); div = 0;
    tick(); tick();
    chk("rstmid_busy_pre", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("rstmid_busy_late", {31'b0, busy}, 32'd0);
    chk("rstmid_hi_late", hi, 32'd0);
    chk("rstmid_lo_late", lo, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
